// File: rtl/slt_sort_pkg.sv
// Shared state encoding, default sizes and index-width helper for slt_sort_ctrl.
package slt_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int N_DEF = 8;
  localparam int K_DEF = 8;

  // Index counters need at least one bit even for the smallest batch.
  function automatic int idx_w(input int k);
    return (k > 2) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/sltN.sv
// Signed N-bit set-less-than: y = {0..0, a<b}, only bit 0 ever carries the result.
module sltN #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};

endmodule

// File: rtl/slt_sort_ctrl.sv
// Bubble sorter sharing one sltN comparator across a K-entry buffer, one compare per cycle.
// Define SLT_SORT_DESC_EN for descending order (default build sorts ascending).
//
// state | meaning
// LOAD  | accept K operands over in_valid/in_ready into mem[wr_idx]
// SORT  | compare/swap mem[cmp_idx], mem[cmp_idx+1]; early exit on a clean pass
// DRAIN | present mem[rd_idx] on out_data until K transfers complete
module slt_sort_ctrl
  import slt_sort_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int IW = idx_w(K);
  localparam logic [IW-1:0] LAST_IDX  = IW'(K - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(K - 2);

  state_e        state_q, state_d;
  logic [N-1:0]  mem_q [K];
  logic [IW-1:0] wr_idx_q, rd_idx_q, pass_q, cmp_idx_q;
  logic          swapped_q;

  logic [IW-1:0] cmp_hi;
  logic [N-1:0]  lo_val, hi_val, cmp_a, cmp_b, slt_y;
  logic          do_swap, pass_end, sort_done, in_fire, out_fire;

  assign cmp_hi = cmp_idx_q + IW'(1);
  assign lo_val = mem_q[cmp_idx_q];
  assign hi_val = mem_q[cmp_hi];

`ifdef SLT_SORT_DESC_EN
  assign cmp_a = lo_val;
  assign cmp_b = hi_val;
`else
  assign cmp_a = hi_val;
  assign cmp_b = lo_val;
`endif

  sltN #(.N(N)) u_slt (
    .a (cmp_a),
    .b (cmp_b),
    .y (slt_y)
  );

  // Upper bits of slt_y are constant zero, so the OR reduces to bit 0.
  assign do_swap   = |slt_y;
  assign pass_end  = (cmp_idx_q == (LAST_PASS - pass_q));
  assign sort_done = pass_end && (!(swapped_q || do_swap) || (pass_q == LAST_PASS));
  assign in_fire   = in_valid && (state_q == LOAD);
  assign out_fire  = out_ready && (state_q == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx_q == LAST_IDX)) state_d = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem_q[rd_idx_q];
        if (out_ready && (rd_idx_q == LAST_IDX)) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) mem_q[i] <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      pass_q    <= '0;
      cmp_idx_q <= '0;
      swapped_q <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (in_fire) begin
            mem_q[wr_idx_q] <= in_data;
            wr_idx_q        <= (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IW'(1);
          end
        end
        SORT: begin
          if (do_swap) begin
            mem_q[cmp_idx_q] <= hi_val;
            mem_q[cmp_hi]    <= lo_val;
          end
          if (pass_end) begin
            cmp_idx_q <= '0;
            swapped_q <= 1'b0;
            pass_q    <= sort_done ? '0 : pass_q + IW'(1);
          end else begin
            cmp_idx_q <= cmp_hi;
            swapped_q <= swapped_q || do_swap;
          end
        end
        DRAIN: begin
          if (out_fire) rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slt_sort_ctrl.sv
// Directed bench for slt_sort_ctrl (K=8, N=8); expectations follow SLT_SORT_DESC_EN.
module tb_slt_sort_ctrl;

  localparam int N = 8;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  slt_sort_ctrl #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int v_mix[8]  = '{5, -3, 127, -128, 0, 1, -1, 2};
  int v_up[8]   = '{0, 1, 2, 3, 4, 5, 6, 7};
  int v_dn[8]   = '{7, 6, 5, 4, 3, 2, 1, 0};
  int v_ext[8]  = '{-128, 127, 0, 0, 1, -1, 64, -64};
  int v_dup[8]  = '{3, 3, -1, -1, 0, 0, 2, 2};

`ifdef SLT_SORT_DESC_EN
  int e_mix[8]  = '{127, 5, 2, 1, 0, -1, -3, -128};
  int e_up[8]   = '{7, 6, 5, 4, 3, 2, 1, 0};
  int e_dn[8]   = '{7, 6, 5, 4, 3, 2, 1, 0};
  int e_ext[8]  = '{127, 64, 1, 0, 0, -1, -64, -128};
  int e_dup[8]  = '{3, 3, 2, 2, 0, 0, -1, -1};
  localparam int LAT_UP = 28;
  localparam int LAT_DN = 7;
`else
  int e_mix[8]  = '{-128, -3, -1, 0, 1, 2, 5, 127};
  int e_up[8]   = '{0, 1, 2, 3, 4, 5, 6, 7};
  int e_dn[8]   = '{0, 1, 2, 3, 4, 5, 6, 7};
  int e_ext[8]  = '{-128, -64, -1, 0, 0, 1, 64, 127};
  int e_dup[8]  = '{-1, -1, 0, 0, 2, 2, 3, 3};
  localparam int LAT_UP = 7;
  localparam int LAT_DN = 28;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input string tag, input int v[8]);
    for (int i = 0; i < K; i++) begin
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = 8'(v[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Counts SORT cycles; keeps in_valid high with junk to show it is ignored.
  task automatic sort_wait(input string tag, output int cyc);
    cyc = 0;
    chk({tag, "_busy_start"}, int'(busy), 1);
    chk({tag, "_in_ready_sort"}, int'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_busy_timeout"}, int'(busy), 0);
  endtask

  task automatic drain(input string tag, input int exp[8], input int stall_at);
    for (int i = 0; i < K; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk({tag, "_stall_valid"}, int'(out_valid), 1);
          chk({tag, "_stall_data"}, $signed(out_data), exp[i]);
        end
      end
      chk({tag, "_out_valid"}, int'(out_valid), 1);
      chk({tag, "_out_data"}, $signed(out_data), exp[i]);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk({tag, "_valid_end"}, int'(out_valid), 0);
    chk({tag, "_in_ready_end"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load("mix", v_mix);
    sort_wait("mix", cyc);
    chk("mix_lat_le28", int'(cyc <= 28), 1);
    chk("mix_lat_ge7", int'(cyc >= 7), 1);
    drain("mix", e_mix, 3);

    load("up", v_up);
    sort_wait("up", cyc);
    chk("up_lat", cyc, LAT_UP);
    drain("up", e_up, 99);

    load("dn", v_dn);
    sort_wait("dn", cyc);
    chk("dn_lat", cyc, LAT_DN);
    drain("dn", e_dn, 0);

    load("ext", v_ext);
    sort_wait("ext", cyc);
    drain("ext", e_ext, 7);

    load("abort", v_dn);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_still_load", int'(in_ready), 1);
    chk("abort_no_output", int'(out_valid), 0);

    load("dup", v_dup);
    sort_wait("dup", cyc);
    drain("dup", e_dup, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
